axi_cmd_master: RTL and testbench
=================================

Name:
axi_cmd_master

Overview:
AXI4 initiator that turns a simple command/stream interface into AXI4 write and read bursts toward the team's axi_interface slave. It converts a single command into AW+W+B or AR+R traffic, with one transaction outstanding at a time. It provides data streams on the user side and reports one completion pulse per command.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (power of two, >=8)
ID_WIDTH, 4, AXI ID width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_id  in  ID_WIDTH  transaction ID
cmd_addr  in  ADDR_WIDTH  start address, must be size-aligned
cmd_len  in  8  beats minus one
wr_data  in  DATA_WIDTH  write beat data
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat consumed
rd_data  out  DATA_WIDTH  read beat data
rd_last  out  1  final read beat
rd_valid  out  1  read beat offered
rd_ready  in  1  read beat consumed
done  out  1  one-cycle completion pulse
done_resp  out  2  completion status (AXI encoding)
awid/arid  out  ID_WIDTH  latched cmd_id
awaddr/araddr  out  ADDR_WIDTH  latched cmd_addr, low log2(DATA_WIDTH/8) bits zeroed
awlen/arlen  out  8  latched cmd_len
awsize/arsize  out  3  constant log2(DATA_WIDTH/8)
awburst/arburst  out  2  constant 2'b01 (INCR)
awvalid/arvalid  out  1  address valid
awready/arready  in  1  address ready
wdata  out  DATA_WIDTH  equals wr_data
wstrb  out  DATA_WIDTH/8  all ones
wlast  out  1  final write beat
wvalid  out  1  write valid
wready  in  1  write ready
bid/rid  in  ID_WIDTH  response ID
bresp/rresp  in  2  response status
bvalid/rvalid  in  1  response valid
bready/rready  out  1  response ready
rdata  in  DATA_WIDTH  read data
rlast  in  1  final read beat

Behaviour:
- Reset (async, resetn low): state IDLE; every valid/ready output, done, and wlast are 0. All latched fields, done_resp, and the beat counter are 0. cmd_ready rises the first cycle after release. Reset mid-transaction aborts it with no done pulse; the slave is reset together.
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA. Registered state; W and R stream paths are combinational.
- IDLE: cmd_ready=1. On cmd_valid, latch the fields and go to WADDR (write) or RADDR (read). The address valid asserts the next cycle.
- WADDR/RADDR: awvalid/arvalid=1. All AW/AR fields stay stable until the ready handshake, then go to WDATA/RDATA. W is never issued before AW completes.
- WDATA: wvalid=wr_valid and wr_ready=wready; elsewhere both are 0. The 8-bit beat counter increments per W handshake. wlast=1 when counter==awlen. A handshake with wlast goes to WRESP.
- WRESP: bready=1. On bvalid, pulse done, with done_resp=bresp, or 2'b10 if bid!=awid. Return to IDLE.
- RDATA: rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=rlast. The counter tracks handshakes. The first non-OKAY rresp is sticky. The error flag is set if rid!=arid, if rlast comes while counter!=arlen, or if counter==arlen without rlast. The block completes only on an rlast handshake. done_resp is the sticky rresp, or 2'b10 if the error flag is set.
- done fires the cycle after the final B/R handshake, with state already IDLE, so cmd_ready=1 that same cycle and back-to-back commands lose no cycle.
- No 4KB-crossing check; the issuer is responsible. The counter does not wrap for len<=255.

Test Plan:
- Write id=1, addr=0xA000_0000, len=0, wr_data=0xDEADBEEF -> awid=1, awlen=0, awsize=2, awburst=01. W carries 0xDEADBEEF, wstrb=F, wlast=1. Then done=1, done_resp=00.
- Read id=2, addr=0xA000_0000, len=0 -> ar fields match; rd_data=0xDEADBEEF, rd_last=1; done_resp=00.
- Write len=3, awready delayed 3 cycles, wr_valid gaps -> awvalid and fields stable; exactly 4 W beats in order; wlast only on beat 4.
- Read len=3, rd_ready low on beat 2 for 2 cycles -> rready low, beat held; 4 beats in order, rd_last on beat 4 only.
- Errors: bresp=10 gives done_resp=10. bid=5 vs awid=1 gives 10. Read len=3 with rlast on beat 2 gives completion on that beat, done_resp=10.
- resetn low during WDATA -> wvalid, awvalid, bready, and done drop immediately; after release, cmd_ready=1 and a fresh write completes normally.

Source files
------------

// File: rtl/axi_cmd_master.sv
// axi_cmd_master: turns a command + data-stream interface into single
// outstanding AXI4 INCR bursts (AW+W+B for writes, AR+R for reads) and
// reports one completion pulse per command.
//
// Handshake rule for every valid/ready pair on this block: a transfer
// happens on a rising clk edge where valid and ready are both high; valid
// never waits for ready, and the payload is held stable while valid is
// high and ready is low.
module axi_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  // command side
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  // write stream
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  // read stream
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  // completion
  output logic                    done,
  output logic [1:0]              done_resp,
  // AXI write address
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI write response
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  // AXI read address
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI read data
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  // debug: current FSM state
  output logic [2:0]              state_dbg
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(STRB_W);
  localparam logic [2:0] SIZE_ENC = 3'(SIZE_LOG2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << SIZE_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WDATA = 3'd2,
    S_WRESP = 3'd3,
    S_RADDR = 3'd4,
    S_RDATA = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // cmd_ready stays low while in reset and rises one clock after release
  logic                  active;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt;
  logic [1:0]            rd_resp_q;   // first non-OKAY rresp of the burst
  logic                  rd_err_q;    // protocol error seen during the burst

  logic cmd_fire;
  logic w_fire;
  logic r_fire;
  logic at_last;
  logic beat_err;
  logic [1:0] rd_resp_sel;

  assign at_last = (cnt == len_q);

  // a read beat is malformed if the ID is wrong or rlast disagrees with the count
  assign beat_err = (rid != id_q) | (rlast & ~at_last) | (~rlast & at_last);
  assign rd_resp_sel = (rd_resp_q != RESP_OKAY) ? rd_resp_q : rresp;

  // latched request fields drive both address channels; only one is ever valid
  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = SIZE_ENC;
  assign awburst = 2'b01;
  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = SIZE_ENC;
  assign arburst = 2'b01;
  assign wdata   = wr_data;
  assign wstrb   = {STRB_W{1'b1}};
  assign rd_data = rdata;
  assign state_dbg = state;

  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // stream gating, handshake strobes and next-state decode
  always_comb begin
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    arvalid   = 1'b0;
    wvalid    = 1'b0;
    wr_ready  = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    rready    = 1'b0;
    state_nxt = state;
    case (state)
      S_IDLE:  cmd_ready = active;
      S_WADDR: awvalid   = 1'b1;
      S_WDATA: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        wlast    = at_last;
      end
      S_WRESP: bready = 1'b1;
      S_RADDR: arvalid = 1'b1;
      S_RDATA: begin
        rd_valid = rvalid;
        rd_last  = rlast;
        rready   = rd_ready;
      end
      default: ;
    endcase

    cmd_fire = cmd_valid & cmd_ready;
    w_fire   = wvalid & wready;
    r_fire   = rvalid & rready;

    case (state)
      S_IDLE:  if (cmd_fire) state_nxt = cmd_write ? S_WADDR : S_RADDR;
      S_WADDR: if (awready) state_nxt = S_WDATA;
      S_WDATA: if (w_fire && wlast) state_nxt = S_WRESP;
      S_WRESP: if (bvalid) state_nxt = S_IDLE;
      S_RADDR: if (arready) state_nxt = S_RDATA;
      S_RDATA: if (r_fire && rlast) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // request latch, beat counter, read status tracking and completion pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active    <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      rd_resp_q <= '0;
      rd_err_q  <= 1'b0;
      done      <= 1'b0;
      done_resp <= '0;
    end else begin
      active <= 1'b1;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            id_q      <= cmd_id;
            addr_q    <= cmd_addr & ADDR_MASK;
            len_q     <= cmd_len;
            cnt       <= '0;
            rd_resp_q <= RESP_OKAY;
            rd_err_q  <= 1'b0;
          end
        end
        S_WDATA: begin
          if (w_fire) cnt <= cnt + 8'd1;
        end
        S_WRESP: begin
          if (bvalid) begin
            done      <= 1'b1;
            done_resp <= (bid != id_q) ? RESP_SLVERR : bresp;
          end
        end
        S_RDATA: begin
          if (r_fire) begin
            cnt <= cnt + 8'd1;
            if (rd_resp_q == RESP_OKAY) rd_resp_q <= rresp;
            if (beat_err) rd_err_q <= 1'b1;
            if (rlast) begin
              done      <= 1'b1;
              done_resp <= (rd_err_q | beat_err) ? RESP_SLVERR : rd_resp_sel;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_cmd_master.sv
// Self-checking bench for axi_cmd_master: a bench-side AXI slave with a
// small memory, user-side drivers, and a scoreboard of expected beats and
// completion responses.
module tb_axi_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [IW-1:0] cmd_id = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [7:0]    cmd_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_valid, rd_ready = 1'b0;
  logic          done;
  logic [1:0]    done_resp;
  logic [IW-1:0] awid, arid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, awready = 1'b0, arvalid, arready = 1'b0;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wlast, wvalid, wready = 1'b0;
  logic [IW-1:0] bid = '0, rid = '0;
  logic [1:0]    bresp = '0, rresp = '0;
  logic          bvalid = 1'b0, bready;
  logic [DW-1:0] rdata = '0;
  logic          rlast = 1'b0, rvalid = 1'b0, rready;
  logic [2:0]    state_dbg;

  axi_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];       // expected W beats or read-stream beats
  logic          exp_last_q[$];  // expected rd_last per read beat
  logic [1:0]    resp_q[$];      // expected done_resp per command
  logic [DW-1:0] mem[logic [AW-1:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // offer one command; caller is between a negedge and the next posedge
  task automatic issue(input logic wr, input logic [IW-1:0] id,
                       input logic [AW-1:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len;
    #1 check("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_id = IW'($urandom); cmd_addr = $urandom; cmd_len = 8'($urandom);
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input int aw_delay, input bit gaps,
                          input logic [1:0] bresp_v, input logic [IW-1:0] bid_v,
                          input logic [1:0] exp_resp, input int abort_beat,
                          input logic [DW-1:0] first_data);
    logic [DW-1:0] src[256];
    logic [AW-1:0] exp_addr;
    int cyc, aw_wait, w_beat, b_cyc;
    bit aw_done, b_done, got_done;
    exp_addr = addr & ~32'h3;
    cyc = 0; aw_wait = 0; w_beat = 0; b_cyc = -10;
    aw_done = 0; b_done = 0; got_done = 0;
    for (int i = 0; i <= int'(len); i++) begin
      src[i] = (i == 0) ? first_data : $urandom;
      exp_q.push_back(src[i]);
    end
    resp_q.push_back(exp_resp);
    issue(1'b1, id, addr, len);
    while (!got_done) begin
      @(negedge clk);
      awready = (aw_wait >= aw_delay);
      wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      wr_data  = (w_beat <= int'(len)) ? src[w_beat] : '0;
      wready   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bvalid   = (w_beat > int'(len)) && !b_done;
      bresp    = bresp_v;
      bid      = bid_v;
      #1;
      if (cyc == 0) begin
        check("aw_latency", awvalid, 1);
        check("done_pulse", done, 0);
      end
      if (abort_beat >= 0 && w_beat == abort_beat && aw_done) begin
        check("pre_rst_wvalid", wvalid, 1);
        resetn = 1'b0;
        #1;
        check("rst_wvalid", wvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_done", done, 0);
        check("rst_wlast", wlast, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", awlen, 0);
        check("rst_done_resp", done_resp, 0);
        repeat (2) @(negedge clk);
        check("rst_hold_done", done, 0);
        resetn = 1'b1; wr_valid = 1'b0; wready = 1'b0; awready = 1'b0; bvalid = 1'b0;
        #1 check("rst_release_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        #1 check("rst_after_cmd_ready", cmd_ready, 1);
        check("rst_after_done", done, 0);
        exp_q.delete();
        resp_q.delete();
        return;
      end
      check("w_before_aw", wvalid & ~aw_done, 0);
      check("aw_once", awvalid & aw_done, 0);
      if (aw_done && w_beat <= int'(len)) check("wr_ready", wr_ready, wready);
      if (awvalid) begin
        check("awid", awid, id);
        check("awaddr", awaddr, exp_addr);
        check("awlen", awlen, len);
        check("awsize", awsize, 3'd2);
        check("awburst", awburst, 2'b01);
        aw_wait++;
        if (awready) aw_done = 1;
      end
      if (wvalid && wready) begin
        if (exp_q.size() == 0) check("w_extra_beat", 1, 0);
        else check("wdata", wdata, exp_q.pop_front());
        check("wstrb", wstrb, 4'hF);
        check("wlast", wlast, w_beat == int'(len));
        if (w_beat <= int'(len)) mem[exp_addr + AW'(4 * w_beat)] = src[w_beat];
        w_beat++;
      end
      if (bvalid && bready) begin
        b_done = 1;
        b_cyc = cyc;
      end
      if (done) begin
        if (resp_q.size() == 0) check("w_extra_done", 1, 0);
        else check("w_done_resp", done_resp, resp_q.pop_front());
        check("w_done_timing", cyc, b_cyc + 1);
        check("w_done_cmd_ready", cmd_ready, 1);
        got_done = 1;
      end
      cyc++;
      if (!got_done && cyc > 300) begin
        check("w_timeout", 0, 1);
        break;
      end
    end
    wr_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input int ar_delay, input int last_beat,
                         input int hold_beat, input logic [1:0] rresp1,
                         input logic [IW-1:0] rid_v, input logic [1:0] exp_resp);
    logic [DW-1:0] src[256];
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] a;
    int cyc, ar_wait, r_beat, r_cyc, hold_cnt;
    bit ar_done, got_done;
    exp_addr = addr & ~32'h3;
    cyc = 0; ar_wait = 0; r_beat = 0; r_cyc = -10; hold_cnt = 0;
    ar_done = 0; got_done = 0;
    for (int i = 0; i <= last_beat; i++) begin
      a = exp_addr + AW'(4 * i);
      src[i] = mem.exists(a) ? mem[a] : $urandom;
      exp_q.push_back(src[i]);
      exp_last_q.push_back(i == last_beat);
    end
    resp_q.push_back(exp_resp);
    issue(1'b0, id, addr, len);
    while (!got_done) begin
      @(negedge clk);
      arready = (ar_wait >= ar_delay);
      rvalid  = ar_done && (r_beat <= last_beat);
      rdata   = (r_beat <= last_beat) ? src[r_beat] : '0;
      rlast   = (r_beat == last_beat);
      rid     = rid_v;
      rresp   = (r_beat == 1) ? rresp1 : 2'b00;
      if (r_beat == hold_beat && hold_cnt < 2) begin
        rd_ready = 1'b0;
        hold_cnt++;
      end else begin
        rd_ready = 1'b1;
      end
      #1;
      if (cyc == 0) begin
        check("ar_latency", arvalid, 1);
        check("done_pulse", done, 0);
      end
      check("ar_once", arvalid & ar_done, 0);
      check("w_in_read", wvalid, 0);
      if (ar_done && r_beat <= last_beat) begin
        check("rready", rready, rd_ready);
        check("rd_valid", rd_valid, 1);
      end
      if (arvalid) begin
        check("arid", arid, id);
        check("araddr", araddr, exp_addr);
        check("arlen", arlen, len);
        check("arsize", arsize, 3'd2);
        check("arburst", arburst, 2'b01);
        ar_wait++;
        if (arready) ar_done = 1;
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) check("r_extra_beat", 1, 0);
        else begin
          check("rd_data", rd_data, exp_q.pop_front());
          check("rd_last", rd_last, exp_last_q.pop_front());
        end
        if (rlast) r_cyc = cyc;
        r_beat++;
      end
      if (done) begin
        if (resp_q.size() == 0) check("r_extra_done", 1, 0);
        else check("r_done_resp", done_resp, resp_q.pop_front());
        check("r_done_timing", cyc, r_cyc + 1);
        check("r_done_cmd_ready", cmd_ready, 1);
        got_done = 1;
      end
      cyc++;
      if (!got_done && cyc > 300) begin
        check("r_timeout", 0, 1);
        break;
      end
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // main sequence
  initial begin
    resetn = 1'b0;
    @(negedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_awvalid", awvalid, 0);
    check("reset_arvalid", arvalid, 0);
    check("reset_wvalid", wvalid, 0);
    check("reset_bready", bready, 0);
    check("reset_rready", rready, 0);
    check("reset_done", done, 0);
    check("reset_done_resp", done_resp, 0);
    check("reset_awaddr", awaddr, 0);
    check("reset_state", state_dbg, 0);
    resetn = 1'b1;
    #1 check("release_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    #1 check("first_cmd_ready", cmd_ready, 1);

    // basic single-beat write then read back
    do_write(4'd1, 32'hA000_0000, 8'd0, 0, 0, 2'b00, 4'd1, 2'b00, -1, 32'hDEAD_BEEF);
    do_read(4'd2, 32'hA000_0000, 8'd0, 0, 0, -1, 2'b00, 4'd2, 2'b00);
    // delayed awready with stream gaps, then back-pressured read
    do_write(4'd3, 32'hA000_0100, 8'd3, 3, 1, 2'b00, 4'd3, 2'b00, -1, $urandom);
    do_read(4'd3, 32'hA000_0100, 8'd3, 1, 3, 1, 2'b00, 4'd3, 2'b00);
    // error responses
    do_write(4'd1, 32'hA000_0200, 8'd1, 0, 0, 2'b10, 4'd1, 2'b10, -1, $urandom);
    do_write(4'd1, 32'hA000_0300, 8'd0, 0, 0, 2'b00, 4'd5, 2'b10, -1, $urandom);
    do_read(4'd4, 32'hA000_0100, 8'd3, 0, 1, -1, 2'b00, 4'd4, 2'b10);
    do_read(4'd6, 32'hA000_0113, 8'd2, 0, 2, -1, 2'b11, 4'd6, 2'b11);
    do_read(4'd7, 32'hA000_0100, 8'd1, 0, 1, -1, 2'b00, 4'd2, 2'b10);
    // reset during WDATA, then a fresh write and read-back
    do_write(4'd2, 32'hA000_0400, 8'd3, 0, 0, 2'b00, 4'd2, 2'b00, 1, $urandom);
    do_write(4'd5, 32'hA000_0500, 8'd1, 1, 0, 2'b00, 4'd5, 2'b00, -1, $urandom);
    do_read(4'd5, 32'hA000_0500, 8'd1, 0, 1, -1, 2'b00, 4'd5, 2'b00);
    // random mix
    for (int n = 0; n < 6; n++) begin
      logic [7:0] l;
      logic [IW-1:0] t;
      logic [AW-1:0] ad;
      l  = 8'($urandom_range(0, 7));
      t  = IW'($urandom);
      ad = 32'hB000_0000 + AW'(n * 256);
      do_write(t, ad, l, $urandom_range(0, 2), 1, 2'b00, t, 2'b00, -1, $urandom);
      do_read(t, ad, l, $urandom_range(0, 2), int'(l), $urandom_range(0, 3), 2'b00, t, 2'b00);
    end

    repeat (2) @(negedge clk);
    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_resp_q_empty", resp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
